inst_loader: RTL and testbench
==============================

// Module: inst_loader
// PURPOSE
//  Boot-time program loader sitting directly upstream of the instruction RAM write port.
//  Consumes a byte stream (UART/debug bridge) carrying a 16-bit word count, then little-endian words.
//  Assembles 32-bit instructions and issues one-cycle RAM writes (is_write/im_addr/im_inst).
//  Holds the core in reset (core_hold) until the image is fully written.
// PARAMETERS
//  W  32  data/address width; must equal the instruction RAM data width
//  H  8   log2 of RAM depth in words; max image = 2**H words
// PORTS
//  clk          in   1   system clock, rising edge
//  rst_n        in   1   asynchronous active-low reset
//  start        in   1   pulse: begin a new load (ignored unless in IDLE, DONE or ERR)
//  byte_valid   in   1   upstream byte available
//  byte_data    in   8   upstream byte
//  byte_ready   out  1   loader accepts byte_data this cycle (transfer = valid & ready)
//  is_write     out  1   one-cycle RAM write strobe
//  im_addr      out  W   RAM byte address (word_index<<2); RAM applies >>2
//  im_inst      out  W   assembled instruction word
//  core_hold    out  1   keep core/PC in reset while high
//  done         out  1   image complete; level, held until next start
//  err          out  1   length exceeds 2**H; level, held until next start
//  words_loaded out  16  count of words written in the current load
// BEHAVIOUR
//  Reset: state=IDLE; byte_ready=0, is_write=0, im_addr=0, im_inst=0, core_hold=1, done=0, err=0, words_loaded=0.
//  States: IDLE -> LEN_LO -> LEN_HI -> (DATA <-> WRITE)* -> DONE | ERR.
//  IDLE: byte_ready=0; start -> LEN_LO, clear done/err/words_loaded/byte_cnt, core_hold=1.
//  LEN_LO: byte_ready=1; on transfer latch len[7:0] -> LEN_HI.
//  LEN_HI: byte_ready=1; on transfer latch len[15:8]; next: len==0 -> DONE; len>2**H -> ERR; else DATA.
//  DATA: byte_ready=1; transfer k (0..3) places byte at im_inst[8k+7:8k]; 4th byte -> WRITE.
//  WRITE: byte_ready=0; is_write=1 exactly this cycle; im_addr=words_loaded<<2; im_inst stable.
//   Next cycle words_loaded+1; if new count==len -> DONE else DATA.
//  Throughput: 1 word per 5 cycles minimum; valid may drop between any bytes (no timeout).
//  DONE: core_hold=0, done=1, byte_ready=0; extra bytes are not accepted.
//  ERR: core_hold=1, err=1, byte_ready=0; no RAM writes ever issued for an oversize length.
//  start while loading (LEN_*, DATA, WRITE): ignored; start in DONE/ERR restarts (core_hold returns to 1 next cycle).
//  len==2**H exactly is legal; last write at im_addr=(2**H-1)<<2; no address wrap possible.
//  im_addr/im_inst hold last values outside WRITE; only is_write qualifies them.
//  Async reset mid-load: immediate return to reset values; partial RAM contents are don't-care.
//  All outputs registered except byte_ready (decoded from state).
// STRUCTURE
//  Shared package/include: state encodings (IDLE..ERR), BYTES_PER_WORD=4, LEN_W=16.
//  Single module; word assembly shift register inline, no sub-module required.
//  Top-level instantiates inst_loader feeding inst_ram1 write port; core reset = ~rst_n | core_hold.
// TESTING
//  1) Reset: rst_n=0 -> core_hold=1, is_write=0, byte_ready=0, done=0, err=0.
//  2) start; bytes 02 00 | 13 00 00 00 | 93 00 10 00 -> writes (0x0,0x00000013),(0x4,0x00100093); done=1, core_hold=0, words_loaded=2.
//  3) Length 0 (00 00) -> DONE, no is_write pulse, core_hold=0.
//  4) Length 0x0101 with H=8 -> ERR, err=1, core_hold=1, zero writes; start -> recovers to LEN_LO.
//  5) Length 0x0100 with byte_valid toggling randomly -> 256 writes, last im_addr=0x3FC; done=1.
//  6) rst_n pulsed low after 3 data bytes -> outputs at reset values; fresh start loads correctly.

Source files
------------

// File: rtl/inst_loader_pkg.sv
// Shared definitions for the boot-time instruction loader.
//   ld_state_e         : loader FSM state encodings
//   BYTES_PER_WORD     : stream bytes per assembled instruction word
//   LEN_W              : width of the word-count header and of words_loaded
//   word_to_byte_addr  : word index -> RAM byte address (index << 2)
package inst_loader_pkg;

   localparam int unsigned BYTES_PER_WORD = 4;
   localparam int unsigned LEN_W          = 16;
   localparam int unsigned BYTE_CNT_W     = $clog2(BYTES_PER_WORD);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LEN_LO = 3'd1,
      S_LEN_HI = 3'd2,
      S_DATA   = 3'd3,
      S_WRITE  = 3'd4,
      S_DONE   = 3'd5,
      S_ERR    = 3'd6
   } ld_state_e;

   function automatic logic [LEN_W+1:0] word_to_byte_addr(input logic [LEN_W-1:0] idx);
      return {idx, 2'b00};
   endfunction

endpackage

// File: rtl/inst_loader.sv
// Boot-time program loader in front of the instruction RAM write port.
// Takes a byte stream: 16-bit little-endian word count, then little-endian
// 32-bit words. Each assembled word is issued as a one-cycle RAM write.
// The core is held in reset until the complete image has been written.
//
// Ports
//   i_clk           system clock, rising edge
//   i_rst_n         asynchronous active-low reset
//   i_start         pulse: begin a new load (honoured in IDLE, DONE, ERR only)
//   i_byte_valid    upstream byte available
//   i_byte_data     upstream byte
//   o_byte_ready    byte accepted this cycle when also valid (decoded from state)
//   o_is_write      one-cycle RAM write strobe
//   o_im_addr       RAM byte address of the write (word index << 2)
//   o_im_inst       assembled instruction word
//   o_core_hold     keep core/PC in reset while high
//   o_done          image complete, held until next start
//   o_err           length exceeded 2**H words, held until next start
//   o_words_loaded  words written in the current load
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | after reset, waiting for start, core held
// S_LEN_LO | accepting low byte of word count
// S_LEN_HI | accepting high byte of word count, range check
// S_DATA   | accepting instruction bytes, LSB first
// S_WRITE  | write strobe high for this single cycle, no byte accepted
// S_DONE   | image complete, core released, stream stalled
// S_ERR    | oversize image rejected, core held, stream stalled
module inst_loader
   import inst_loader_pkg::*;
#(
   parameter int W = 32,
   parameter int H = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic             i_byte_valid,
   input  logic [7:0]       i_byte_data,
   output logic             o_byte_ready,
   output logic             o_is_write,
   output logic [W-1:0]     o_im_addr,
   output logic [W-1:0]     o_im_inst,
   output logic             o_core_hold,
   output logic             o_done,
   output logic             o_err,
   output logic [LEN_W-1:0] o_words_loaded
);

   localparam int unsigned MAX_WORDS = 32'd1 << H;
   localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(BYTES_PER_WORD - 1);

   ld_state_e             r_state;
   logic [LEN_W-1:0]      r_len;
   logic [BYTE_CNT_W-1:0] r_byte_cnt;
   logic [W-9:0]          r_shift;
   logic                  r_is_write;
   logic [W-1:0]          r_im_addr;
   logic [W-1:0]          r_im_inst;
   logic                  r_core_hold;
   logic                  r_done;
   logic                  r_err;
   logic [LEN_W-1:0]      r_words_loaded;

   logic                  w_ready;
   logic                  w_xfer;
   logic [LEN_W-1:0]      w_len_full;
   logic [LEN_W-1:0]      w_cnt_inc;

   always_comb begin
      w_ready = 1'b0;
      case (r_state)
         S_LEN_LO, S_LEN_HI, S_DATA: w_ready = 1'b1;
         default:                    w_ready = 1'b0;
      endcase
   end

   assign w_xfer     = i_byte_valid & w_ready;
   assign w_len_full = {i_byte_data, r_len[7:0]};
   assign w_cnt_inc  = r_words_loaded + 1'b1;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state        <= S_IDLE;
         r_len          <= '0;
         r_byte_cnt     <= '0;
         r_shift        <= '0;
         r_is_write     <= 1'b0;
         r_im_addr      <= '0;
         r_im_inst      <= '0;
         r_core_hold    <= 1'b1;
         r_done         <= 1'b0;
         r_err          <= 1'b0;
         r_words_loaded <= '0;
      end else begin
         r_is_write <= 1'b0;
         case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
               if (i_start) begin
                  r_state        <= S_LEN_LO;
                  r_done         <= 1'b0;
                  r_err          <= 1'b0;
                  r_words_loaded <= '0;
                  r_byte_cnt     <= '0;
                  r_core_hold    <= 1'b1;
               end
            end

            S_LEN_LO: begin
               if (w_xfer) begin
                  r_len[7:0] <= i_byte_data;
                  r_state    <= S_LEN_HI;
               end
            end

            S_LEN_HI: begin
               if (w_xfer) begin
                  r_len[15:8] <= i_byte_data;
                  if (w_len_full == '0) begin
                     r_state     <= S_DONE;
                     r_done      <= 1'b1;
                     r_core_hold <= 1'b0;
                  end else if (32'(w_len_full) > MAX_WORDS) begin
                     r_state <= S_ERR;
                     r_err   <= 1'b1;
                  end else begin
                     r_state <= S_DATA;
                  end
               end
            end

            S_DATA: begin
               if (w_xfer) begin
                  if (r_byte_cnt == LAST_BYTE) begin
                     // Final byte lands on the top lane; earlier bytes were
                     // shifted down so byte 0 ends at bits [7:0]. The
                     // output word only changes here, so it is stable
                     // outside the write cycle.
                     r_im_inst  <= {i_byte_data, r_shift};
                     r_im_addr  <= W'(word_to_byte_addr(r_words_loaded));
                     r_is_write <= 1'b1;
                     r_byte_cnt <= '0;
                     r_state    <= S_WRITE;
                  end else begin
                     r_shift    <= {i_byte_data, r_shift[W-9:8]};
                     r_byte_cnt <= r_byte_cnt + 1'b1;
                  end
               end
            end

            S_WRITE: begin
               r_words_loaded <= w_cnt_inc;
               if (w_cnt_inc == r_len) begin
                  r_state     <= S_DONE;
                  r_done      <= 1'b1;
                  r_core_hold <= 1'b0;
               end else begin
                  r_state <= S_DATA;
               end
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_byte_ready   = w_ready;
   assign o_is_write     = r_is_write;
   assign o_im_addr      = r_im_addr;
   assign o_im_inst      = r_im_inst;
   assign o_core_hold    = r_core_hold;
   assign o_done         = r_done;
   assign o_err          = r_err;
   assign o_words_loaded = r_words_loaded;

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: expected RAM writes are queued as bytes
// are driven and popped whenever the write strobe is seen.
module tb_inst_loader;

   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic        i_start;
   logic        i_byte_valid;
   logic [7:0]  i_byte_data;
   logic        o_byte_ready;
   logic        o_is_write;
   logic [31:0] o_im_addr;
   logic [31:0] o_im_inst;
   logic        o_core_hold;
   logic        o_done;
   logic        o_err;
   logic [15:0] o_words_loaded;

   int          n_assert = 0;
   int          n_fail   = 0;
   int          n_writes = 0;
   logic [63:0] sb[$];
   logic [31:0] img[$];

   always #5 i_clk = ~i_clk;

   inst_loader #(.W(32), .H(8)) dut (
      .i_clk          (i_clk),
      .i_rst_n        (i_rst_n),
      .i_start        (i_start),
      .i_byte_valid   (i_byte_valid),
      .i_byte_data    (i_byte_data),
      .o_byte_ready   (o_byte_ready),
      .o_is_write     (o_is_write),
      .o_im_addr      (o_im_addr),
      .o_im_inst      (o_im_inst),
      .o_core_hold    (o_core_hold),
      .o_done         (o_done),
      .o_err          (o_err),
      .o_words_loaded (o_words_loaded)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock and sample just after the edge; any write strobe is
   // matched against the head of the scoreboard.
   task automatic tick();
      logic [63:0] exp;
      @(posedge i_clk);
      #1;
      if (o_is_write) begin
         n_writes++;
         check("write_expected", 32'(sb.size() > 0), 32'd1);
         if (sb.size() > 0) begin
            exp = sb.pop_front();
            check("im_addr", o_im_addr, exp[63:32]);
            check("im_inst", o_im_inst, exp[31:0]);
         end
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input bit rnd);
      int gap;
      int budget;
      bit got;
      gap = rnd ? int'($urandom_range(0, 2)) : 0;
      for (int g = 0; g < gap; g++) begin
         i_byte_valid = 1'b0;
         tick();
      end
      i_byte_valid = 1'b1;
      i_byte_data  = b;
      got    = 1'b0;
      budget = 0;
      while (!got && budget < 50) begin
         got = o_byte_ready;
         tick();
         budget++;
      end
      i_byte_valid = 1'b0;
      check("byte_accepted", 32'(got), 32'd1);
   endtask

   task automatic do_start();
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
   endtask

   task automatic load(input logic [15:0] len, input bit rnd);
      logic [31:0] a;
      send_byte(len[7:0], rnd);
      send_byte(len[15:8], rnd);
      for (int i = 0; i < img.size(); i++) begin
         a = 32'(i * 4);
         sb.push_back({a, img[i]});
         for (int k = 0; k < 4; k++) send_byte(img[i][8*k +: 8], rnd);
      end
   endtask

   task automatic wait_end();
      int b;
      b = 0;
      while (!(o_done || o_err) && b < 30) begin
         tick();
         b++;
      end
      check("end_reached", 32'(o_done | o_err), 32'd1);
   endtask

   initial begin
      int w0;
      i_rst_n      = 1'b0;
      i_start      = 1'b0;
      i_byte_valid = 1'b0;
      i_byte_data  = 8'h00;

      // 1) reset values
      repeat (3) tick();
      check("rst_core_hold",  32'(o_core_hold),  32'd1);
      check("rst_is_write",   32'(o_is_write),   32'd0);
      check("rst_byte_ready", 32'(o_byte_ready), 32'd0);
      check("rst_done",       32'(o_done),       32'd0);
      check("rst_err",        32'(o_err),        32'd0);
      check("rst_words",      32'(o_words_loaded), 32'd0);
      check("rst_im_addr",    o_im_addr,         32'd0);
      i_rst_n = 1'b1;
      tick();
      check("idle_byte_ready", 32'(o_byte_ready), 32'd0);

      // 2) two-word image
      do_start();
      check("lenlo_ready", 32'(o_byte_ready), 32'd1);
      img.delete();
      img.push_back(32'h0000_0013);
      img.push_back(32'h0010_0093);
      load(16'd2, 1'b0);
      wait_end();
      check("t2_done",      32'(o_done),      32'd1);
      check("t2_core_hold", 32'(o_core_hold), 32'd0);
      check("t2_words",     32'(o_words_loaded), 32'd2);
      check("t2_writes",    32'(n_writes),    32'd2);
      check("t2_sb_empty",  32'(sb.size()),   32'd0);
      // bytes offered in DONE are not taken
      i_byte_valid = 1'b1;
      i_byte_data  = 8'hAA;
      repeat (3) tick();
      check("done_no_ready", 32'(o_byte_ready), 32'd0);
      i_byte_valid = 1'b0;
      check("done_words_kept", 32'(o_words_loaded), 32'd2);
      check("done_no_writes",  32'(n_writes),       32'd2);

      // 3) zero-length image
      do_start();
      check("restart_hold", 32'(o_core_hold), 32'd1);
      check("restart_done_clr", 32'(o_done), 32'd0);
      w0 = n_writes;
      img.delete();
      load(16'd0, 1'b0);
      wait_end();
      check("t3_done",      32'(o_done),      32'd1);
      check("t3_core_hold", 32'(o_core_hold), 32'd0);
      check("t3_no_write",  32'(n_writes - w0), 32'd0);

      // 4) oversize length, then recovery
      do_start();
      w0 = n_writes;
      load(16'h0101, 1'b0);
      wait_end();
      check("t4_err",       32'(o_err),       32'd1);
      check("t4_done",      32'(o_done),      32'd0);
      check("t4_core_hold", 32'(o_core_hold), 32'd1);
      check("t4_ready",     32'(o_byte_ready), 32'd0);
      repeat (3) tick();
      check("t4_no_write",  32'(n_writes - w0), 32'd0);
      do_start();
      check("t4_rec_ready", 32'(o_byte_ready), 32'd1);
      check("t4_rec_err",   32'(o_err),        32'd0);
      check("t4_rec_hold",  32'(o_core_hold),  32'd1);
      img.delete();
      img.push_back(32'hDEAD_BEEF);
      load(16'd1, 1'b0);
      wait_end();
      check("t4_rec_done",  32'(o_done),       32'd1);
      check("t4_rec_words", 32'(o_words_loaded), 32'd1);

      // 5) maximum image with a stalling source
      do_start();
      w0 = n_writes;
      img.delete();
      for (int i = 0; i < 256; i++) img.push_back($urandom());
      load(16'h0100, 1'b1);
      wait_end();
      check("t5_done",      32'(o_done),        32'd1);
      check("t5_writes",    32'(n_writes - w0), 32'd256);
      check("t5_last_addr", o_im_addr,          32'h0000_03FC);
      check("t5_last_inst", o_im_inst,          img[255]);
      check("t5_words",     32'(o_words_loaded), 32'd256);
      check("t5_sb_empty",  32'(sb.size()),     32'd0);

      // 6) reset in the middle of a word
      do_start();
      send_byte(8'h02, 1'b0);
      send_byte(8'h00, 1'b0);
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b0);
      send_byte(8'h33, 1'b0);
      #2;
      i_rst_n = 1'b0;
      #1;
      check("t6_core_hold", 32'(o_core_hold),  32'd1);
      check("t6_ready",     32'(o_byte_ready), 32'd0);
      check("t6_done",      32'(o_done),       32'd0);
      check("t6_words",     32'(o_words_loaded), 32'd0);
      check("t6_im_inst",   o_im_inst,         32'd0);
      sb.delete();
      tick();
      i_rst_n = 1'b1;
      tick();
      do_start();
      w0 = n_writes;
      img.delete();
      img.push_back(32'h1234_5678);
      load(16'd1, 1'b0);
      wait_end();
      check("t6_fresh_done",   32'(o_done),        32'd1);
      check("t6_fresh_writes", 32'(n_writes - w0), 32'd1);
      check("t6_fresh_addr",   o_im_addr,          32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
